// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM (fetch/decode/execute/mem/writeback)
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : unsupported opcode in DECODE sets illegal and halts
//   undefined : unsupported opcode runs as a NOP, illegal tied 0
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   instr[31:0]             instruction register contents (valid from DECODE)
//   br_eq, br_lt            branch comparator results
//   imem_req / imem_ready   instruction fetch handshake
//   dmem_req, dmem_we / dmem_ready   data memory handshake
//   ir_we, pc_we, rf_we     IR / PC / register-file write enables
//   pc_sel                  0 = pc+4, 1 = ALU result
//   imm_sel[2:0]            immediate format (IMM_I/S/B/U/J)
//   a_sel, b_sel, alu_add   operand muxes and forced-add control
//   wb_sel[1:0]             0 = ALU, 1 = memory data, 2 = pc+4
//   halted, bus_err, illegal   sticky status
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        br_eq,
  input  logic        br_lt,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        pc_sel,
  output logic [2:0]  imm_sel,
  output logic        a_sel,
  output logic        b_sel,
  output logic        alu_add,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        bus_err,
  output logic        illegal
);

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          pc_sel_q, pc_sel_d;
  logic          bus_err_q, bus_err_d;
  logic          imem_req_c, ir_we_c;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       rd_zero;
  logic       unused_instr_bits;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign rd_zero = (instr[11:7] == 5'd0);
  assign unused_instr_bits = &{1'b0, instr[31:15]};

  // Opcode decode into operand/writeback controls
  logic       is_load, is_store, is_branch, is_jump, supported;
  logic [2:0] dec_imm;
  logic       dec_a, dec_b, dec_add;
  logic [1:0] dec_wb;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    supported = 1'b1;
    dec_imm   = IMM_I;
    dec_a     = 1'b0;
    dec_b     = 1'b0;
    dec_add   = 1'b0;
    dec_wb    = 2'd0;
    case (opcode)
      OPC_OP:     ;
      OPC_OPIMM:  dec_b = 1'b1;
      OPC_LOAD:   begin is_load = 1'b1; dec_b = 1'b1; dec_add = 1'b1; dec_wb = 2'd1; end
      OPC_STORE:  begin is_store = 1'b1; dec_imm = IMM_S; dec_b = 1'b1; dec_add = 1'b1; end
      OPC_LUI:    begin dec_imm = IMM_U; dec_b = 1'b1; end
      OPC_AUIPC:  begin dec_imm = IMM_U; dec_a = 1'b1; dec_b = 1'b1; dec_add = 1'b1; end
      OPC_JAL:    begin
        is_jump = 1'b1; dec_imm = IMM_J; dec_a = 1'b1; dec_b = 1'b1;
        dec_add = 1'b1; dec_wb = 2'd2;
      end
      OPC_JALR:   begin is_jump = 1'b1; dec_b = 1'b1; dec_add = 1'b1; dec_wb = 2'd2; end
      OPC_BRANCH: begin
        is_branch = 1'b1; dec_imm = IMM_B; dec_a = 1'b1; dec_b = 1'b1; dec_add = 1'b1;
      end
      default:    supported = 1'b0;
    endcase
  end

  // Only BEQ/BNE/BLT/BGE are resolved here; other funct3 values fall through not-taken
  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = ~br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = ~br_lt;
      default: br_taken = 1'b0;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    pc_sel_d   = pc_sel_q;
    bus_err_d  = bus_err_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    imem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    imm_sel    = IMM_I;
    a_sel      = 1'b0;
    b_sel      = 1'b0;
    alu_add    = 1'b0;
    wb_sel     = 2'd0;

    // Decoded controls stay stable from DECODE through WB
    if (state_q inside {S_DECODE, S_EXECUTE, S_MEM, S_WB}) begin
      imm_sel = dec_imm;
      a_sel   = dec_a;
      b_sel   = dec_b;
      alu_add = dec_add;
      wb_sel  = dec_wb;
    end

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!supported) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
`endif
      end
      S_EXECUTE: begin
        pc_sel_d = is_jump | (is_branch & br_taken);
        if (is_load | is_store) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_WB: begin
        pc_we    = 1'b1;
        rf_we    = supported & ~is_store & ~is_branch & ~rd_zero;
        pc_sel_d = 1'b0;
        wait_d   = '0;
        state_d  = S_FETCH;
      end
      default: ;
    endcase
  end

  // Reset parks the FSM in FETCH; gating the fetch outputs with rst_n keeps
  // them low while reset is held without waiting for a clock edge.
  assign imem_req = imem_req_c & rst_n;
  assign ir_we    = ir_we_c & rst_n;
  assign pc_sel   = pc_sel_q;
  assign halted   = (state_q == S_HALT);
  assign bus_err  = bus_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      pc_sel_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pc_sel_q  <= pc_sel_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        br_eq, br_lt;
  logic        imem_req, imem_ready;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        ir_we, pc_we, rf_we, pc_sel;
  logic [2:0]  imm_sel;
  logic        a_sel, b_sel, alu_add;
  logic [1:0]  wb_sel;
  logic        halted, bus_err, illegal;

  multicycle_controller #(.TIMEOUT_CYCLES(256)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .br_eq(br_eq), .br_lt(br_lt),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .pc_sel(pc_sel),
    .imm_sel(imm_sel), .a_sel(a_sel), .b_sel(b_sel), .alu_add(alu_add),
    .wb_sel(wb_sel), .halted(halted), .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Observations from one instruction run
  int         r_wb_cyc, r_req_cyc, r_we_cyc, r_halt_cyc;
  logic       r_rf_seen, r_ir_we1, r_pc_sel, r_a_sel, r_b_sel, r_alu_add, r_rf_wb, r_illegal;
  logic [1:0] r_wb_sel;
  logic [2:0] r_dec_imm;

  // Entered at posedge+1 with the FSM in FETCH; returns at posedge+1 after WB (or on halt)
  task automatic run_instr(input logic [31:0] i, input int dly, input logic eq, input logic lt);
    bit done;
    done = 0;
    instr = i; br_eq = eq; br_lt = lt; imem_ready = 1'b1; dmem_ready = 1'b0;
    r_wb_cyc = 0; r_req_cyc = 0; r_we_cyc = 0; r_halt_cyc = 0;
    r_rf_seen = 0; r_ir_we1 = 0; r_pc_sel = 0; r_a_sel = 0; r_b_sel = 0;
    r_alu_add = 0; r_rf_wb = 0; r_illegal = 0; r_wb_sel = 0; r_dec_imm = 3'd7;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      #1;
      dmem_ready = dmem_req && (r_req_cyc == dly);
      #1;
      if (cyc == 1) r_ir_we1 = ir_we;
      if (cyc == 2) r_dec_imm = imm_sel;
      if (dmem_req) r_req_cyc++;
      if (dmem_we) r_we_cyc++;
      if (rf_we) r_rf_seen = 1'b1;
      if (pc_we) begin
        r_wb_cyc = cyc; r_pc_sel = pc_sel; r_a_sel = a_sel; r_b_sel = b_sel;
        r_alu_add = alu_add; r_wb_sel = wb_sel; r_rf_wb = rf_we;
        done = 1;
      end
      if (halted) begin
        r_halt_cyc = cyc; r_illegal = illegal;
        done = 1;
      end
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
  endtask

  int halt_cyc;

  initial begin
    rst_n = 1'b0; instr = 32'h0; br_eq = 0; br_lt = 0;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_ir_we", ir_we, 0);
    check("rst_pc_we", pc_we, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_imm_sel", imm_sel, IMM_I);
    check("rst_status", {halted, bus_err, illegal, pc_sel}, 0);
    check("rst_sel", {a_sel, b_sel, alu_add, wb_sel}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADDI x1, x0, 1
    run_instr(32'h00100093, 0, 0, 0);
    check("addi_ir_we", r_ir_we1, 1);
    check("addi_imm", r_dec_imm, IMM_I);
    check("addi_wb_cyc", r_wb_cyc, 4);
    check("addi_rf_we", r_rf_wb, 1);
    check("addi_b_sel", r_b_sel, 1);
    check("addi_pc_sel", r_pc_sel, 0);
    check("addi_no_dmem", r_req_cyc, 0);

    // SW with three wait states
    run_instr(32'h00102123, 3, 0, 0);
    check("sw_imm", r_dec_imm, IMM_S);
    check("sw_req_cycles", r_req_cyc, 4);
    check("sw_we_cycles", r_we_cyc, 4);
    check("sw_rf_we", r_rf_seen, 0);
    check("sw_wb_cyc", r_wb_cyc, 8);
    check("sw_alu_add", r_alu_add, 1);

    // LW x1, 4(x0), zero wait states
    run_instr(32'h00402083, 0, 0, 0);
    check("lw_wb_cyc", r_wb_cyc, 5);
    check("lw_wb_sel", r_wb_sel, 1);
    check("lw_rf_we", r_rf_wb, 1);
    check("lw_req_cycles", r_req_cyc, 1);
    check("lw_we_cycles", r_we_cyc, 0);

    // BEQ taken / not taken
    run_instr(32'h00100263, 0, 1, 0);
    check("beq_t_imm", r_dec_imm, IMM_B);
    check("beq_t_pc_sel", r_pc_sel, 1);
    check("beq_t_rf_we", r_rf_seen, 0);
    check("beq_t_sel", {r_a_sel, r_b_sel, r_alu_add}, 3'b111);
    run_instr(32'h00100263, 0, 0, 0);
    check("beq_nt_pc_sel", r_pc_sel, 0);
    check("beq_nt_wb_cyc", r_wb_cyc, 4);

    // BNE with equal operands: not taken; BLT with lt: taken; BGE with lt: not taken
    run_instr(32'h00101263, 0, 1, 0);
    check("bne_pc_sel", r_pc_sel, 0);
    run_instr(32'h00104263, 0, 0, 1);
    check("blt_pc_sel", r_pc_sel, 1);
    run_instr(32'h00105263, 0, 0, 1);
    check("bge_pc_sel", r_pc_sel, 0);

    // JAL x1, 8
    run_instr(32'h008000ef, 0, 0, 0);
    check("jal_imm", r_dec_imm, IMM_J);
    check("jal_a_sel", r_a_sel, 1);
    check("jal_wb_sel", r_wb_sel, 2);
    check("jal_pc_sel", r_pc_sel, 1);
    check("jal_rf_we", r_rf_wb, 1);

    // JALR x1, 0(x2)
    run_instr(32'h000100e7, 0, 0, 0);
    check("jalr_sel", {r_a_sel, r_b_sel, r_alu_add, r_pc_sel}, 4'b0111);
    check("jalr_wb_sel", r_wb_sel, 2);

    // ADDI x0: no register write
    run_instr(32'h00100013, 0, 0, 0);
    check("addi_x0_rf_we", r_rf_seen, 0);

    // LUI x1: U immediate, ALU writeback, b=imm
    run_instr(32'h000010b7, 0, 0, 0);
    check("lui_imm", r_dec_imm, IMM_U);
    check("lui_wb_sel", r_wb_sel, 0);
    check("lui_b_sel", r_b_sel, 1);
    check("lui_rf_we", r_rf_wb, 1);

    // OP (ADD x1,x1,x2): register operands, decoded ALU
    run_instr(32'h002080b3, 0, 0, 0);
    check("op_sel", {r_a_sel, r_b_sel, r_alu_add}, 3'b000);

    // Unsupported opcode
    run_instr(32'hFFFFFFFF, 0, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill_halt_cyc", r_halt_cyc, 3);
    check("ill_illegal", r_illegal, 1);
    check("ill_no_pc_we", r_wb_cyc, 0);
`else
    check("ill_nop_wb_cyc", r_wb_cyc, 4);
    check("ill_nop_rf_we", r_rf_seen, 0);
    check("ill_nop_illegal", illegal, 0);
    check("ill_nop_halted", r_halt_cyc, 0);
`endif

    // Fetch timeout
    rst_n = 1'b0; imem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    halt_cyc = 0;
    for (int cyc = 1; cyc <= 400 && halt_cyc == 0; cyc++) begin
      #1;
      if (cyc == 1) check("to_req_first", imem_req, 1);
      if (cyc == 256) check("to_req_last", {imem_req, bus_err}, 2'b10);
      if (halted) halt_cyc = cyc;
      else begin
        @(posedge clk); #1;
      end
    end
    check("to_halt_cyc", halt_cyc, 257);
    check("to_bus_err", bus_err, 1);
    check("to_req_drop", imem_req, 0);
    imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("halt_absorb", {halted, ir_we, imem_req, pc_we}, 4'b1000);

    // Asynchronous reset pulse clears status and returns to FETCH
    #2 rst_n = 1'b0;
    #1;
    check("arst_status", {halted, bus_err, illegal, imem_req}, 0);
    @(posedge clk); #1;
    imem_ready = 1'b1; instr = 32'h00102123;
    rst_n = 1'b1;
    #1;
    check("arst_fetch", imem_req, 1);

    // Reset dropped in the middle of a store handshake
    dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_dmem_req", {dmem_req, dmem_we}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_drop", {dmem_req, dmem_we, pc_we, rf_we, ir_we, imem_req}, 0);
    @(posedge clk); #1;
    check("mid_rst_hold", {dmem_req, pc_we, rf_we}, 0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
